// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter sharing one fixed-latency single-ported memory
module mem_port_arbiter #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int LAT  = 2,
  parameter int PRIO = 0
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_nRD,
  output logic          mem_nWR,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam int CW = $clog2(LAT) + 1;
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q;
  logic          owner_q;
  logic          we_q;
  logic          last_owner_q;
  logic [CW-1:0] cnt_q;
  logic          grant_data_d;

  // Round-robin hands a tie to whichever port did not own the previous access.
  always_comb begin
    grant_data_d = 1'b0;
    if (d_req && !i_req) begin
      grant_data_d = 1'b1;
    end else if (d_req && i_req) begin
      grant_data_d = (PRIO != 0) ? 1'b1 : (last_owner_q == OWN_FETCH);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_FETCH;
      we_q         <= 1'b0;
      last_owner_q <= OWN_DATA;
      cnt_q        <= '0;
      i_ack        <= 1'b0;
      d_ack        <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_nRD      <= 1'b1;
      mem_nWR      <= 1'b1;
      busy         <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            owner_q  <= grant_data_d;
            we_q     <= grant_data_d & d_we;
            mem_addr <= grant_data_d ? d_addr : i_addr;
            if (grant_data_d) begin
              mem_wdata <= d_wdata;
            end
            mem_nRD <= grant_data_d & d_we;
            mem_nWR <= ~(grant_data_d & d_we);
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + CW'(1);
          // Read data is valid at the end of the last strobe cycle.
          if (cnt_q == CW'(LAT - 1)) begin
            if (!we_q) begin
              if (owner_q == OWN_DATA) begin
                d_rdata <= mem_rdata;
              end else begin
                i_rdata <= mem_rdata;
              end
            end
            mem_nRD      <= 1'b1;
            mem_nWR      <= 1'b1;
            i_ack        <= (owner_q == OWN_FETCH);
            d_ack        <= (owner_q == OWN_DATA);
            last_owner_q <= owner_q;
            state_q      <= RESP;
          end
        end
        RESP: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [2:0]  i_ack_w, d_ack_w, nrd_w, nwr_w, busy_w;
  logic [2:0][31:0] i_rdata_w, d_rdata_w, maddr_w, mwdata_w;
  int sel;
  int total, bad;

  logic [31:0] phys_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  // DUT 0: LAT=2 round-robin, DUT 1: LAT=2 data priority, DUT 2: LAT=1 round-robin
  mem_port_arbiter #(.AW(32), .DW(32), .LAT(2), .PRIO(0)) u_rr (
    .CLK(clk), .Reset(rst), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack_w[0]),
    .i_rdata(i_rdata_w[0]), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack_w[0]), .d_rdata(d_rdata_w[0]), .mem_addr(maddr_w[0]), .mem_wdata(mwdata_w[0]),
    .mem_nRD(nrd_w[0]), .mem_nWR(nwr_w[0]), .mem_rdata(mem_rdata), .busy(busy_w[0]));
  mem_port_arbiter #(.AW(32), .DW(32), .LAT(2), .PRIO(1)) u_pr (
    .CLK(clk), .Reset(rst), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack_w[1]),
    .i_rdata(i_rdata_w[1]), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack_w[1]), .d_rdata(d_rdata_w[1]), .mem_addr(maddr_w[1]), .mem_wdata(mwdata_w[1]),
    .mem_nRD(nrd_w[1]), .mem_nWR(nwr_w[1]), .mem_rdata(mem_rdata), .busy(busy_w[1]));
  mem_port_arbiter #(.AW(32), .DW(32), .LAT(1), .PRIO(0)) u_l1 (
    .CLK(clk), .Reset(rst), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack_w[2]),
    .i_rdata(i_rdata_w[2]), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack_w[2]), .d_rdata(d_rdata_w[2]), .mem_addr(maddr_w[2]), .mem_wdata(mwdata_w[2]),
    .mem_nRD(nrd_w[2]), .mem_nWR(nwr_w[2]), .mem_rdata(mem_rdata), .busy(busy_w[2]));

  function automatic logic [31:0] bg(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    if (phys_mem.exists(a)) return phys_mem[a];
    return bg(a);
  endfunction
  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return bg(a);
  endfunction

  // Behavioural memory attached to the selected DUT
  always @(negedge clk) mem_rdata = nrd_w[sel] ? 32'h0 : phys_rd(maddr_w[sel]);
  always @(posedge clk) if (!nwr_w[sel]) phys_mem[maddr_w[sel]] = mwdata_w[sel];

  task automatic apply_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_xfer(input bit is_d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                         output int ack_k, output int n_rd, output int n_wr,
                         output logic [31:0] rd, output logic [31:0] a_seen);
    ack_k = -1; n_rd = 0; n_wr = 0; rd = '0; a_seen = '0;
    @(negedge clk);
    if (is_d) begin d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; end
    else begin i_req = 1'b1; i_addr = a; end
    for (int k = 1; k <= 20 && ack_k < 0; k++) begin
      @(negedge clk);
      if (!nrd_w[sel]) begin n_rd++; a_seen = maddr_w[sel]; end
      if (!nwr_w[sel]) begin n_wr++; a_seen = maddr_w[sel]; end
      if (is_d ? d_ack_w[sel] : i_ack_w[sel]) begin
        ack_k = k;
        rd = is_d ? d_rdata_w[sel] : i_rdata_w[sel];
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++; if ({i_ack_w[k], d_ack_w[k], busy_w[k]} !== 3'b000) begin
        bad++; $display("FAIL reset_acks_busy dut%0d: got %b expected 000", k, {i_ack_w[k], d_ack_w[k], busy_w[k]}); end
      total++; if ({nrd_w[k], nwr_w[k]} !== 2'b11) begin
        bad++; $display("FAIL reset_strobes dut%0d: got %b expected 11", k, {nrd_w[k], nwr_w[k]}); end
      total++; if ({i_rdata_w[k], d_rdata_w[k], maddr_w[k], mwdata_w[k]} !== 128'h0) begin
        bad++; $display("FAIL reset_data dut%0d: got %h expected 0", k, {i_rdata_w[k], d_rdata_w[k], maddr_w[k], mwdata_w[k]}); end
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    int ak, nr, nw; logic [31:0] rd, as;
    sel = 0; phys_mem[32'h10] = 32'hDEAD_BEEF;
    do_xfer(1'b0, 1'b0, 32'h10, 32'h0, ak, nr, nw, rd, as);
    total++; if (ak !== 3) begin bad++; $display("FAIL fetch_ack_cycle: got %0d expected 3", ak); end
    total++; if (nr !== 2 || nw !== 0) begin bad++; $display("FAIL fetch_strobes: got rd=%0d wr=%0d expected rd=2 wr=0", nr, nw); end
    total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fetch_rdata: got %h expected deadbeef", rd); end
    total++; if (as !== 32'h10) begin bad++; $display("FAIL fetch_addr: got %h expected 10", as); end
    @(negedge clk);
    total++; if (i_ack_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
      bad++; $display("FAIL fetch_ack_pulse: got ack=%b busy=%b expected 0 0", i_ack_w[0], busy_w[0]); end
    total++; if (i_rdata_w[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fetch_rdata_hold: got %h expected deadbeef", i_rdata_w[0]); end
  endtask

  task automatic test_store();
    int ak, nr, nw; logic [31:0] rd, as;
    sel = 0;
    do_xfer(1'b1, 1'b1, 32'h40, 32'h1234_5678, ak, nr, nw, rd, as);
    total++; if (ak !== 3) begin bad++; $display("FAIL store_ack_cycle: got %0d expected 3", ak); end
    total++; if (nw !== 2 || nr !== 0) begin bad++; $display("FAIL store_strobes: got rd=%0d wr=%0d expected rd=0 wr=2", nr, nw); end
    total++; if (as !== 32'h40) begin bad++; $display("FAIL store_addr: got %h expected 40", as); end
    total++; if (phys_rd(32'h40) !== 32'h1234_5678) begin bad++; $display("FAIL store_mem: got %h expected 12345678", phys_rd(32'h40)); end
  endtask

  task automatic test_tie(input int s, input bit prio1);
    int got[$]; int exp_o[4]; bit ri, rdf; int nd, nds; bit last_d, w;
    last_d = 1'b1; nd = 0;
    for (int g = 0; g < 4; g++) begin
      if (prio1 && nd >= 2) w = 1'b0;
      else if (prio1) w = 1'b1;
      else w = !last_d;
      last_d = w; if (w) nd++;
      exp_o[g] = int'(w);
    end
    sel = s; rst = 1'b1; d_we = 1'b0;
    i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_addr = 32'h200;
    repeat (2) @(negedge clk);
    rst = 1'b0; ri = 1'b0; rdf = 1'b0; nds = 0;
    for (int c = 0; c < 80 && got.size() < 4; c++) begin
      @(negedge clk);
      if (ri) begin i_req = 1'b1; ri = 1'b0; end
      if (rdf) begin d_req = 1'b1; rdf = 1'b0; end
      if (i_ack_w[sel]) begin got.push_back(0); i_req = 1'b0; ri = 1'b1; end
      if (d_ack_w[sel]) begin got.push_back(1); d_req = 1'b0; nds++; rdf = !(prio1 && nds >= 2); end
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (got.size() !== 4) begin bad++; $display("FAIL tie_count prio%0d: got %0d expected 4", prio1, got.size()); end
    for (int g = 0; g < 4 && g < got.size(); g++) begin
      total++; if (got[g] !== exp_o[g]) begin
        bad++; $display("FAIL tie_order prio%0d grant%0d: got %0d expected %0d (1=data)", prio1, g, got[g], exp_o[g]); end
    end
  endtask

  task automatic test_late_request();
    int ik, dk; logic b4; logic [31:0] ir, dr;
    sel = 0; apply_reset();
    ik = -1; dk = -1; b4 = 1'bx; ir = '0; dr = '0;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h20;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) begin d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; end
      if (k == 4) b4 = busy_w[0];
      if (i_ack_w[0]) begin ik = k; ir = i_rdata_w[0]; i_req = 1'b0; end
      if (d_ack_w[0]) begin dk = k; dr = d_rdata_w[0]; d_req = 1'b0; end
    end
    total++; if (ik !== 3) begin bad++; $display("FAIL late_fetch_ack: got %0d expected 3", ik); end
    total++; if (dk !== 7) begin bad++; $display("FAIL late_data_ack: got %0d expected 7", dk); end
    total++; if (b4 !== 1'b0) begin bad++; $display("FAIL late_idle_gap: got busy=%b expected 0", b4); end
    total++; if (dr !== phys_rd(32'h80)) begin bad++; $display("FAIL late_d_rdata: got %h expected %h", dr, phys_rd(32'h80)); end
    total++; if (ir !== phys_rd(32'h20)) begin bad++; $display("FAIL late_i_rdata: got %h expected %h", ir, phys_rd(32'h20)); end
  endtask

  task automatic test_reset_abort();
    int dk; logic [31:0] dr;
    sel = 0; apply_reset();
    dk = -1; dr = '0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    for (int k = 1; k <= 15 && dk < 0; k++) begin
      @(negedge clk);
      if (k == 2) rst = 1'b1;
      if (k == 3) begin
        total++; if ({nrd_w[0], nwr_w[0], d_ack_w[0], busy_w[0]} !== 4'b1100) begin
          bad++; $display("FAIL abort_state: got nrd,nwr,ack,busy=%b expected 1100", {nrd_w[0], nwr_w[0], d_ack_w[0], busy_w[0]}); end
        total++; if (d_rdata_w[0] !== 32'h0) begin bad++; $display("FAIL abort_rdata: got %h expected 0", d_rdata_w[0]); end
        rst = 1'b0;
      end
      if (d_ack_w[0]) begin dk = k; dr = d_rdata_w[0]; d_req = 1'b0; end
    end
    d_req = 1'b0;
    total++; if (dk !== 6) begin bad++; $display("FAIL abort_reissue_ack: got %0d expected 6", dk); end
    total++; if (dr !== phys_rd(32'h44)) begin bad++; $display("FAIL abort_reissue_rdata: got %h expected %h", dr, phys_rd(32'h44)); end
  endtask

  task automatic test_lat1();
    int ak, nr, nw; logic [31:0] rd, as;
    sel = 2; apply_reset();
    do_xfer(1'b0, 1'b0, 32'h10, 32'h0, ak, nr, nw, rd, as);
    total++; if (ak !== 2) begin bad++; $display("FAIL lat1_fetch_ack: got %0d expected 2", ak); end
    total++; if (nr !== 1) begin bad++; $display("FAIL lat1_fetch_strobe: got %0d expected 1", nr); end
    total++; if (rd !== phys_rd(32'h10)) begin bad++; $display("FAIL lat1_fetch_rdata: got %h expected %h", rd, phys_rd(32'h10)); end
    do_xfer(1'b1, 1'b1, 32'h48, 32'hA5A5_0001, ak, nr, nw, rd, as);
    total++; if (ak !== 2 || nw !== 1) begin bad++; $display("FAIL lat1_store: got ack=%0d wr=%0d expected 2 1", ak, nw); end
    total++; if (phys_rd(32'h48) !== 32'hA5A5_0001) begin bad++; $display("FAIL lat1_store_mem: got %h expected a5a50001", phys_rd(32'h48)); end
  endtask

  task automatic test_random(input int s, input int lat);
    int i_left, d_left, i_gap, d_gap, i_t0, d_t0, strb, hi;
    bit i_pend, d_pend, d_st;
    logic [31:0] ia, da, dw;
    sel = s; apply_reset();
    model_mem = phys_mem;
    hi = 2 * lat + 3;
    i_left = 20; d_left = 20; i_gap = $urandom_range(0, 2); d_gap = $urandom_range(0, 2);
    i_pend = 1'b0; d_pend = 1'b0; d_st = 1'b0; strb = 0; i_t0 = 0; d_t0 = 0;
    ia = '0; da = '0; dw = '0;
    for (int cyc = 0; cyc < 3000 && (i_left > 0 || d_left > 0 || i_pend || d_pend); cyc++) begin
      @(negedge clk);
      if (!nrd_w[sel] || !nwr_w[sel]) strb++;
      total++; if ((!nrd_w[sel] && !nwr_w[sel]) || (i_ack_w[sel] && d_ack_w[sel])) begin
        bad++; $display("FAIL rnd_overlap: got nrd=%b nwr=%b iack=%b dack=%b", nrd_w[sel], nwr_w[sel], i_ack_w[sel], d_ack_w[sel]); end
      if (i_ack_w[sel]) begin
        total++; if (!i_pend) begin bad++; $display("FAIL rnd_i_spurious: got ack with no request"); end
        else begin
          total++; if (i_rdata_w[sel] !== model_rd(ia)) begin bad++; $display("FAIL rnd_i_rdata: got %h expected %h", i_rdata_w[sel], model_rd(ia)); end
          total++; if (strb !== lat) begin bad++; $display("FAIL rnd_i_strobe: got %0d expected %0d", strb, lat); end
          total++; if (cyc - i_t0 < lat + 1 || cyc - i_t0 > hi) begin
            bad++; $display("FAIL rnd_i_latency: got %0d expected %0d..%0d", cyc - i_t0, lat + 1, hi); end
          i_pend = 1'b0; i_req = 1'b0; i_gap = $urandom_range(1, 3);
        end
      end
      if (d_ack_w[sel]) begin
        total++; if (!d_pend) begin bad++; $display("FAIL rnd_d_spurious: got ack with no request"); end
        else begin
          if (d_st) model_mem[da] = dw;
          else begin
            total++; if (d_rdata_w[sel] !== model_rd(da)) begin bad++; $display("FAIL rnd_d_rdata: got %h expected %h", d_rdata_w[sel], model_rd(da)); end
          end
          total++; if (strb !== lat) begin bad++; $display("FAIL rnd_d_strobe: got %0d expected %0d", strb, lat); end
          total++; if (cyc - d_t0 < lat + 1 || cyc - d_t0 > hi) begin
            bad++; $display("FAIL rnd_d_latency: got %0d expected %0d..%0d", cyc - d_t0, lat + 1, hi); end
          d_pend = 1'b0; d_req = 1'b0; d_gap = $urandom_range(1, 3);
        end
      end
      if (i_ack_w[sel] || d_ack_w[sel]) strb = 0;
      if (!i_pend && i_left > 0) begin
        if (i_gap > 0) i_gap--;
        else begin
          ia = 32'($urandom_range(0, 15)) << 2;
          i_addr = ia; i_req = 1'b1; i_pend = 1'b1; i_t0 = cyc; i_left--;
        end
      end
      if (!d_pend && d_left > 0) begin
        if (d_gap > 0) d_gap--;
        else begin
          da = 32'($urandom_range(0, 15)) << 2; dw = $urandom; d_st = 1'($urandom_range(0, 1));
          d_addr = da; d_wdata = dw; d_we = d_st; d_req = 1'b1; d_pend = 1'b1; d_t0 = cyc; d_left--;
        end
      end
    end
    total++; if (i_left != 0 || d_left != 0 || i_pend || d_pend) begin
      bad++; $display("FAIL rnd_timeout: got left i=%0d d=%0d expected 0", i_left + int'(i_pend), d_left + int'(d_pend)); end
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0; sel = 0; rst = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_rdata = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    test_reset();
    test_fetch();
    test_store();
    test_tie(0, 1'b0);
    test_tie(1, 1'b1);
    test_late_request();
    test_reset_abort();
    test_lat1();
    test_random(0, 2);
    test_random(2, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
